// File: rtl/mem_dpi_arbiter.sv
// mem_dpi_arbiter: shares one memory DPI port among N_CLIENTS burst requesters.
// Grants whole bursts round-robin and holds the grant until the final beat completes.
// Write beats flow owner -> memory; read beats flow memory -> owner (data broadcast).
// Optional feature: define MEM_ARB_PERF_EN to add perf_clear / perf_beats per-client
// completed-beat counters.
module mem_dpi_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int LEN_BITS  = 8,
    parameter int ADDR_BITS = 64,
    parameter int DATA_BITS = 64
) (
    input  logic                           clock,
    input  logic                           reset,
`ifdef MEM_ARB_PERF_EN
    input  logic                           perf_clear,
    output logic [N_CLIENTS*32-1:0]        perf_beats,
`endif
    input  logic [N_CLIENTS-1:0]           cl_req_valid,
    output logic [N_CLIENTS-1:0]           cl_req_ready,
    input  logic [N_CLIENTS-1:0]           cl_req_opcode,
    input  logic [N_CLIENTS*LEN_BITS-1:0]  cl_req_len,
    input  logic [N_CLIENTS*ADDR_BITS-1:0] cl_req_addr,
    input  logic [N_CLIENTS-1:0]           cl_wr_valid,
    output logic [N_CLIENTS-1:0]           cl_wr_ready,
    input  logic [N_CLIENTS*DATA_BITS-1:0] cl_wr_bits,
    output logic [N_CLIENTS-1:0]           cl_rd_valid,
    input  logic [N_CLIENTS-1:0]           cl_rd_ready,
    output logic [DATA_BITS-1:0]           cl_rd_bits,
    output logic                           mem_req_valid,
    output logic                           mem_req_opcode,
    output logic [LEN_BITS-1:0]            mem_req_len,
    output logic [ADDR_BITS-1:0]           mem_req_addr,
    output logic                           mem_wr_valid,
    output logic [DATA_BITS-1:0]           mem_wr_bits,
    input  logic                           mem_rd_valid,
    input  logic [DATA_BITS-1:0]           mem_rd_bits,
    output logic                           mem_rd_ready
);

    localparam int CW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       owner_q, owner_d;
    logic [CW-1:0]       last_q, last_d;
    logic [LEN_BITS-1:0] beats_q, beats_d;

    logic                anyReq;
    logic [CW-1:0]       grantIdx;
    logic                beatFire;

    // Round-robin pick: the first requester found scanning last+1, last+2, ... wraps mod N.
    // Scanning from the far end lets the nearest candidate overwrite the others.
    always_comb begin
        anyReq   = 1'b0;
        grantIdx = '0;
        for (int k = N_CLIENTS; k >= 1; k--) begin
            if (cl_req_valid[(int'(last_q) + k) % N_CLIENTS]) begin
                anyReq   = 1'b1;
                grantIdx = CW'((int'(last_q) + k) % N_CLIENTS);
            end
        end
    end

    // Next-state and output logic; everything is forced to 0 while reset is asserted.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        beats_d        = beats_q;
        cl_req_ready   = '0;
        cl_wr_ready    = '0;
        cl_rd_valid    = '0;
        cl_rd_bits     = '0;
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;
        beatFire       = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        cl_req_ready[grantIdx] = 1'b1;
                        mem_req_valid          = 1'b1;
                        mem_req_opcode         = cl_req_opcode[grantIdx];
                        mem_req_len            = cl_req_len[int'(grantIdx)*LEN_BITS +: LEN_BITS];
                        mem_req_addr           = cl_req_addr[int'(grantIdx)*ADDR_BITS +: ADDR_BITS];
                        owner_d                = grantIdx;
                        beats_d                = cl_req_len[int'(grantIdx)*LEN_BITS +: LEN_BITS];
                        state_d                = cl_req_opcode[grantIdx] ? WRITE : READ;
                    end
                end
                READ: begin
                    cl_rd_valid[owner_q] = mem_rd_valid;
                    mem_rd_ready         = cl_rd_ready[owner_q];
                    cl_rd_bits           = mem_rd_bits;
                    beatFire             = mem_rd_valid & cl_rd_ready[owner_q];
                end
                WRITE: begin
                    cl_wr_ready[owner_q] = 1'b1;
                    mem_wr_valid         = cl_wr_valid[owner_q];
                    mem_wr_bits          = cl_wr_bits[int'(owner_q)*DATA_BITS +: DATA_BITS];
                    beatFire             = cl_wr_valid[owner_q];
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // beats_q holds beats-1, so the final beat is the one seen at zero.
            if (beatFire) begin
                if (beats_q == '0) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else begin
                    beats_d = beats_q - 1'b1;
                end
            end
        end
    end

    // State register; reset gives client 0 first priority by parking last at N-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= CW'(N_CLIENTS - 1);
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_q [N_CLIENTS];

    // Per-client completed-beat counters; a clear beats a same-cycle increment.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (reset || perf_clear) begin
                perf_q[i] <= '0;
            end else if (beatFire && (owner_q == CW'(i))) begin
                perf_q[i] <= perf_q[i] + 32'd1;
            end
        end
    end

    // Pack the counters onto the flat output port.
    always_comb begin
        perf_beats = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            perf_beats[i*32 +: 32] = perf_q[i];
        end
    end
`endif

endmodule
